key_conditioner: RTL and testbench

Input-conditioning stage directly upstream of the pinball/piano top-level mux: takes the raw `move[2:0]` push-button pins and produces clean, debounced levels plus single-cycle press, release and auto-repeat strobes. These drive `to_left`/`to_right` for the pinball game and `key` for the piano. Each key channel is independent. All outputs are synchronous to `sys_clk`.

---
 rtl/key_pkg.sv | 27 ++
 rtl/key_channel.sv | 142 ++++++++++++++
 rtl/key_conditioner.sv | 38 +++
 tb/tb_key_conditioner.sv | 149 ++++++++++++++
 4 files changed

// File: rtl/key_pkg.sv
// Shared types and constants for the push-button conditioning stage.
package key_pkg;

    // Auto-repeat state per key channel.
    typedef enum logic [1:0] {
        IDLE        = 2'd0,
        HOLD_DELAY  = 2'd1,
        HOLD_REPEAT = 2'd2
    } rpt_state_e;

    // Bit positions of the individual buttons in the key vectors.
    localparam int KEY_LEFT  = 0;
    localparam int KEY_MID   = 1;
    localparam int KEY_RIGHT = 2;

    // Default timing at 50 MHz: 5 ms debounce, 0.5 s repeat delay, 0.1 s period.
    localparam int DEF_N_KEYS          = 3;
    localparam int DEF_DEBOUNCE_CYCLES = 250000;
    localparam int DEF_REPEAT_DELAY    = 25000000;
    localparam int DEF_REPEAT_PERIOD   = 5000000;

    // Width of a counter that must hold values 0..value; never below one bit.
    function automatic int cnt_width(input int value);
        return (value < 1) ? 1 : $clog2(value + 1);
    endfunction

endpackage

// File: rtl/key_channel.sv
// One key: 2-flop synchronizer, debounce counter and auto-repeat FSM.
module key_channel
    import key_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
    parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
    input  logic sys_clk,
    input  logic reset,
    input  logic key_raw,
    output logic key_level,
    output logic key_press,
    output logic key_release,
    output logic key_strobe
);

    localparam int DCNT_W = cnt_width(DEBOUNCE_CYCLES);
    localparam int RMAX   = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RCNT_W = cnt_width(RMAX);

    localparam logic [DCNT_W-1:0] DCNT_LAST   = DCNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [DCNT_W-1:0] DCNT_MAX    = '1;
    localparam logic [RCNT_W-1:0] DELAY_LAST  = RCNT_W'((REPEAT_DELAY > 0) ? REPEAT_DELAY - 1 : 0);
    localparam logic [RCNT_W-1:0] PERIOD_LAST = RCNT_W'((REPEAT_PERIOD > 0) ? REPEAT_PERIOD - 1 : 0);
    localparam logic [RCNT_W-1:0] RCNT_MAX    = '1;

    logic              sync1_q;
    logic              sync2_q;
    logic [DCNT_W-1:0] dcnt_q;
    logic [DCNT_W-1:0] dcnt_d;
    logic              level_q;
    logic              level_d;
    logic              press_q;
    logic              release_q;
    logic              strobe_q;
    logic [RCNT_W-1:0] rcnt_q;
    rpt_state_e        state_q;

    logic accept;
    logic rise;
    logic fall;

    // Bring the asynchronous pin into the clock domain.
    always_ff @(posedge sys_clk or posedge reset) begin
        if (reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= key_raw;
            sync2_q <= sync1_q;
        end
    end

    // Count consecutive samples that disagree with the accepted level; any agreeing sample restarts.
    always_comb begin
        dcnt_d  = '0;
        level_d = level_q;
        if (sync2_q != level_q) begin
            if (dcnt_q == DCNT_LAST) begin
                level_d = ~level_q;
            end else if (dcnt_q != DCNT_MAX) begin
                dcnt_d = dcnt_q + DCNT_W'(1);
            end else begin
                dcnt_d = dcnt_q;
            end
        end
    end

    assign accept = (level_d != level_q);
    assign rise   = accept & ~level_q;
    assign fall   = accept &  level_q;

    // Debounce state and the single-cycle edge pulses.
    always_ff @(posedge sys_clk or posedge reset) begin
        if (reset) begin
            dcnt_q    <= '0;
            level_q   <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
        end else begin
            dcnt_q    <= dcnt_d;
            level_q   <= level_d;
            press_q   <= rise;
            release_q <= fall;
        end
    end

    // Auto-repeat FSM; a release always wins over a coinciding repeat.
    always_ff @(posedge sys_clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            rcnt_q   <= '0;
            strobe_q <= 1'b0;
        end else begin
            strobe_q <= 1'b0;
            if (fall) begin
                state_q <= IDLE;
                rcnt_q  <= '0;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (rise) begin
                            strobe_q <= 1'b1;
                            rcnt_q   <= '0;
                            if (REPEAT_DELAY != 0) begin
                                state_q <= HOLD_DELAY;
                            end
                        end
                    end
                    HOLD_DELAY: begin
                        if (rcnt_q == DELAY_LAST) begin
                            strobe_q <= 1'b1;
                            rcnt_q   <= '0;
                            state_q  <= HOLD_REPEAT;
                        end else if (rcnt_q != RCNT_MAX) begin
                            rcnt_q <= rcnt_q + RCNT_W'(1);
                        end
                    end
                    HOLD_REPEAT: begin
                        if (rcnt_q == PERIOD_LAST) begin
                            strobe_q <= 1'b1;
                            rcnt_q   <= '0;
                        end else if (rcnt_q != RCNT_MAX) begin
                            rcnt_q <= rcnt_q + RCNT_W'(1);
                        end
                    end
                    default: begin
                        state_q <= IDLE;
                        rcnt_q  <= '0;
                    end
                endcase
            end
        end
    end

    assign key_level   = level_q;
    assign key_press   = press_q;
    assign key_release = release_q;
    assign key_strobe  = strobe_q;

endmodule

// File: rtl/key_conditioner.sv
// Debounce and auto-repeat for all push buttons; channels are fully independent.
module key_conditioner
    import key_pkg::*;
#(
    parameter int N_KEYS          = DEF_N_KEYS,
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
    parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
    input  logic              sys_clk,
    input  logic              reset,
    input  logic [N_KEYS-1:0] key_raw,
    output logic [N_KEYS-1:0] key_level,
    output logic [N_KEYS-1:0] key_press,
    output logic [N_KEYS-1:0] key_release,
    output logic [N_KEYS-1:0] key_strobe
);

    genvar gi;
    generate
        for (gi = 0; gi < N_KEYS; gi++) begin : g_chan
            key_channel #(
                .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
                .REPEAT_DELAY    (REPEAT_DELAY),
                .REPEAT_PERIOD   (REPEAT_PERIOD)
            ) u_chan (
                .sys_clk     (sys_clk),
                .reset       (reset),
                .key_raw     (key_raw[gi]),
                .key_level   (key_level[gi]),
                .key_press   (key_press[gi]),
                .key_release (key_release[gi]),
                .key_strobe  (key_strobe[gi])
            );
        end
    endgenerate

endmodule

// File: tb/tb_key_conditioner.sv
// Directed bench: DEBOUNCE_CYCLES=4, REPEAT_PERIOD=3, REPEAT_DELAY=10 and 0.
module tb_key_conditioner;

    logic       sys_clk = 1'b0;
    logic       reset   = 1'b1;
    logic [2:0] key_raw = 3'b000;

    logic [2:0] lvl_a, prs_a, rel_a, stb_a;
    logic [2:0] lvl_b, prs_b, rel_b, stb_b;

    int n_asserts = 0;
    int n_fail    = 0;

    always #5 sys_clk = ~sys_clk;

    key_conditioner #(
        .N_KEYS(3), .DEBOUNCE_CYCLES(4), .REPEAT_DELAY(10), .REPEAT_PERIOD(3)
    ) dut (
        .sys_clk(sys_clk), .reset(reset), .key_raw(key_raw),
        .key_level(lvl_a), .key_press(prs_a), .key_release(rel_a), .key_strobe(stb_a)
    );

    key_conditioner #(
        .N_KEYS(3), .DEBOUNCE_CYCLES(4), .REPEAT_DELAY(0), .REPEAT_PERIOD(3)
    ) dut0 (
        .sys_clk(sys_clk), .reset(reset), .key_raw(key_raw),
        .key_level(lvl_b), .key_press(prs_b), .key_release(rel_b), .key_strobe(stb_b)
    );

    task automatic cmp(input string name, input logic [2:0] obs, input logic [2:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%b expected=%b", name, obs, exp);
        end
    endtask

    // Both instances share level/press/release; the no-repeat one strobes only on press.
    task automatic check_all(input string tag, input logic [2:0] el, input logic [2:0] ep,
                             input logic [2:0] er, input logic [2:0] es);
        cmp({tag, " level"},    lvl_a, el);
        cmp({tag, " press"},    prs_a, ep);
        cmp({tag, " release"},  rel_a, er);
        cmp({tag, " strobe"},   stb_a, es);
        cmp({tag, " level0"},   lvl_b, el);
        cmp({tag, " press0"},   prs_b, ep);
        cmp({tag, " release0"}, rel_b, er);
        cmp({tag, " strobe0"},  stb_b, ep);
    endtask

    task automatic step();
        @(negedge sys_clk);
    endtask

    // Clean press on mask, raw dropped after edge 'hold'; checks every edge up to 'total'.
    task automatic run_press(input string tag, input logic [2:0] mask, input int hold, input int total);
        logic [2:0] el, ep, er, es;
        int rel;
        rel = hold + 6;
        key_raw = mask;
        for (int e = 1; e <= total; e++) begin
            step();
            el = (e >= 6 && e < rel) ? mask : 3'b000;
            ep = (e == 6) ? mask : 3'b000;
            er = (e == rel) ? mask : 3'b000;
            es = (e == 6 || (e >= 16 && e < rel && ((e - 16) % 3) == 0)) ? mask : 3'b000;
            check_all($sformatf("%s e=%0d", tag, e), el, ep, er, es);
            if (e == hold) key_raw = 3'b000;
        end
        $display("txn %s mask=%b hold=%0d done", tag, mask, hold);
    endtask

    initial begin
        logic [8:0] bounce;
        bounce = 9'b111101101;

        // Reset state
        #3;
        check_all("reset", 3'b000, 3'b000, 3'b000, 3'b000);
        step();
        step();
        reset = 1'b0;
        step();
        check_all("post_reset", 3'b000, 3'b000, 3'b000, 3'b000);
        $display("txn reset checked");

        // 1: clean press held 40 cycles; the repeat due at release is suppressed
        run_press("press40", 3'b001, 40, 50);

        // 2: bounce on key 2, accepted 4 stable samples after final rise
        for (int i = 0; i < 9; i++) begin
            key_raw = {bounce[i], 2'b00};
            step();
            check_all($sformatf("bounce i=%0d", i), 3'b000, 3'b000, 3'b000, 3'b000);
        end
        step();
        check_all("bounce e10", 3'b000, 3'b000, 3'b000, 3'b000);
        step();
        check_all("bounce e11", 3'b100, 3'b100, 3'b000, 3'b100);
        step();
        check_all("bounce e12", 3'b100, 3'b000, 3'b000, 3'b000);
        key_raw = 3'b000;
        for (int e = 1; e <= 6; e++) begin
            step();
            check_all($sformatf("bounce rel e=%0d", e), (e < 6) ? 3'b100 : 3'b000,
                      3'b000, (e == 6) ? 3'b100 : 3'b000, 3'b000);
        end
        $display("txn bounce key2 done");

        // 3: 3-cycle glitch on key 1 must be ignored
        key_raw = 3'b010;
        for (int e = 1; e <= 13; e++) begin
            step();
            check_all($sformatf("glitch e=%0d", e), 3'b000, 3'b000, 3'b000, 3'b000);
            if (e == 3) key_raw = 3'b000;
        end
        $display("txn glitch key1 done");

        // 4: level held 13 cycles, release coincides with a due repeat
        run_press("rel_vs_rpt", 3'b001, 13, 22);

        // 5: keys 0 and 2 together
        run_press("dual", 3'b101, 20, 30);

        // 6: reset in HOLD_REPEAT while the key stays down
        key_raw = 3'b001;
        for (int e = 1; e <= 19; e++) step();
        check_all("pre_rst e19", 3'b001, 3'b000, 3'b000, 3'b001);
        #2 reset = 1'b1;
        #1 check_all("async_rst", 3'b000, 3'b000, 3'b000, 3'b000);
        step();
        check_all("rst_held1", 3'b000, 3'b000, 3'b000, 3'b000);
        step();
        check_all("rst_held2", 3'b000, 3'b000, 3'b000, 3'b000);
        reset = 1'b0;
        $display("txn reset mid-repeat applied");
        run_press("after_rst", 3'b001, 12, 20);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout observed=running expected=finished");
        $fatal(1, "watchdog");
    end

endmodule
